scan_chain_host: RTL and testbench
==================================

# scan_chain_host

Host-side driver for the DES scan chain. It takes a byte stream from the SPI front end and serialises each bit onto `scan_in` with `scan_enable` asserted. At the same time it captures `scan_out` and returns the previous chain contents as a byte stream. One session shifts exactly `CHAIN_LEN` bits, so the chain ends up holding the written vector and the host receives the old one.

## Interface
Parameters:
- `CHAIN_LEN`, default 136: total scan-chain length in bits, 1..1024. `NBYTES` = ceil(`CHAIN_LEN`/8).

Ports:
- `clk`  in  1  single clock, shared with the target chain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a session; sampled in IDLE only.
- `target_busy`  in  1  target is mid-operation; a session may not start while this is high.
- `busy`  out  1  high while in LOAD, SHIFT or PUSH.
- `done`  out  1  one-cycle pulse at the end of a session.
- `in_data`  in  8  next write byte, bits LSB-first.
- `in_valid`  in  1  write byte available.
- `in_ready`  out  1  block accepts the write byte.
- `out_data`  out  8  readback byte.
- `out_valid`  out  1  readback byte available.
- `out_ready`  in  1  consumer accepts the readback byte.
- `scan_enable`  out  1  to chain; high only in SHIFT.
- `scan_in`  out  1  to the chain's first cell.
- `scan_out`  in  1  from the chain's last cell.

## Operation
- Stream bit i = 8*byte + bit index, with bit 0 of byte 0 first.
- In shift cycle i:
  - `scan_in` = write bit i;
  - the `scan_out` value present in that cycle becomes readback bit i.
- Registers: `tx[7:0]`, `rx[7:0]`, `nbit` (bits left in the current byte), `remaining` (bits left in the session).
- States:
  - **IDLE**
    - All handshake outputs are low.
    - `start && !target_busy` → LOAD, with `remaining` = `CHAIN_LEN`.
    - `start` while `target_busy` = 1 is ignored.
  - **LOAD**
    - `in_ready` = 1.
    - On `in_valid`: `tx` ← `in_data`, `rx` ← 0, `nbit` ← min(8, `remaining`) → SHIFT.
  - **SHIFT**
    - `scan_enable` = 1, `scan_in` = `tx[0]`.
    - Each cycle: `tx` >>= 1, capture `scan_out` into `rx`, decrement `nbit` and `remaining`.
    - When `nbit` reaches 0 → PUSH.
  - **PUSH**
    - `out_valid` = 1, `out_data` = `rx`.
    - In a partial last byte (n < 8 bits), readback bits occupy [n-1:0] and bits [7:n] are 0.
    - On `out_ready`: go to DONE if `remaining` = 0, otherwise to LOAD.
  - **DONE**: `done` = 1 for one cycle, then → IDLE.
- Outputs are decoded from registered state. `scan_in` = 0 outside SHIFT.
- Over one session, `scan_enable` is high for exactly `CHAIN_LEN` cycles, never more.
- Stalls:
  - `scan_enable` is low whenever the block waits for input or output, so the chain holds.
  - The target must stay idle for the whole session; `target_busy` is checked at start only.
- `start` outside IDLE is ignored. In-bound bytes outside LOAD are not accepted.
- `out_data` is stable while `out_valid && !out_ready`.
- Reset:
  - `rst_n` low forces IDLE immediately.
  - All outputs become 0, `scan_enable` included, with no wait for a clock edge.
  - A partially shifted chain is left as is.

## Timing
- `start` accepted at edge t → LOAD from cycle t+1, with `busy` = `in_ready` = 1.
- Input handshake in cycle c → SHIFT in cycles c+1..c+n → `out_valid` from cycle c+n+1.
- Per full byte, with no backpressure: 10 cycles (LOAD 1, SHIFT 8, PUSH 1).
- Minimum session: 10*(`NBYTES`-1) + (n+2) + 1 cycles from the first LOAD to DONE, where n is the bit count of the last byte.
- `done` is asserted in the cycle after the final `out_valid && out_ready` handshake. `busy` is 0 in that cycle.
- Back-to-back sessions are possible: `start` can be accepted in the cycle after DONE.

## Test plan
1. **Reset.** Hold `rst_n` low with random inputs → `busy`, `done`, `in_ready`, `out_valid`, `scan_enable`, `scan_in` = 0 and `out_data` = 0.
2. **Full round trip.** `CHAIN_LEN` = 136 against a 136-bit shift-register model initialised to 0.
   - Session 1 writes 0x00..0x10 → readback is 17× 0x00.
   - Session 2 writes 17× 0xFF → readback is 0x00..0x10.
   - `scan_enable` is high for exactly 136 cycles per session, and `done` pulses once per session.
3. **Partial byte.** `CHAIN_LEN` = 12.
   - Write 0xA5, 0x0F → `scan_enable` high for 8 cycles, then 4 cycles.
   - Next session readback is 0xA5, 0x0F, with upper bits 0.
4. **Backpressure and gaps.**
   - Hold `out_ready` = 0 for 20 cycles in PUSH → `out_data` stable, `scan_enable` = 0, model contents unchanged.
   - Insert `in_valid` gaps of 5 cycles → final chain contents still match the written bytes.
5. **Start gating.**
   - `start` with `target_busy` = 1 → stays in IDLE and `busy` = 0.
   - `start` pulses during a session → no effect, and the session is still exactly `CHAIN_LEN` shifts.
6. **Reset mid-SHIFT.**
   - Assert `rst_n` low at shift bit 3 of byte 5 → `scan_enable` drops immediately and `busy` = 0.
   - After release, a full session completes normally with correct readback.

Source files
------------

// File: rtl/scan_chain_host.sv
// scan_chain_host: host-side scan-chain driver. Each write byte is shifted
// onto the chain LSB-first while scan_enable is high. Bits coming back on
// scan_out are collected and returned as readback bytes. One session shifts
// exactly CHAIN_LEN bits.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start, target_busy     session request; ignored while target_busy is high
//   busy, done             session active / one-cycle end pulse
//   in_data/valid/ready    write byte stream (LSB first)
//   out_data/valid/ready   readback byte stream
//   scan_enable, scan_in   to the chain; scan_out from the chain
module scan_chain_host #(
  parameter int unsigned CHAIN_LEN = 136
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       target_busy,
  output logic       busy,
  output logic       done,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out
);
  localparam int unsigned RW_MIN = $clog2(CHAIN_LEN + 1);
  // At least 4 bits, so the constant 8 fits in the min(8, remaining) compare.
  localparam int unsigned RW = (RW_MIN < 4) ? 4 : RW_MIN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_PUSH,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [3:0]    nbit_q, nbit_d;
  logic [2:0]    bpos_q, bpos_d;
  logic [RW-1:0] remaining_q, remaining_d;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    nbit_d      = nbit_q;
    bpos_d      = bpos_q;
    remaining_d = remaining_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !target_busy) begin
          state_d     = S_LOAD;
          remaining_d = RW'(CHAIN_LEN);
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          tx_d    = in_data;
          rx_d    = '0;
          bpos_d  = '0;
          nbit_d  = (remaining_q >= RW'(8)) ? 4'd8 : remaining_q[3:0];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        tx_d         = {1'b0, tx_q[7:1]};
        // Readback is written by bit position rather than shifted in, so a
        // partial last byte lands in [n-1:0] with the upper bits left at 0.
        rx_d[bpos_q] = scan_out;
        bpos_d       = bpos_q + 3'd1;
        nbit_d       = nbit_q - 4'd1;
        remaining_d  = remaining_q - RW'(1);
        if (nbit_q == 4'd1) begin
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (out_ready) begin
          state_d = (remaining_q == '0) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      nbit_q      <= '0;
      bpos_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      nbit_q      <= nbit_d;
      bpos_q      <= bpos_d;
      remaining_q <= remaining_d;
    end
  end

  // Decoded from registered state only; reset drives them all low at once.
  assign busy        = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_PUSH);
  assign done        = (state_q == S_DONE);
  assign in_ready    = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_PUSH);
  assign out_data    = (state_q == S_PUSH) ? rx_q : '0;
  assign scan_enable = (state_q == S_SHIFT);
  assign scan_in     = (state_q == S_SHIFT) ? tx_q[0] : 1'b0;

endmodule

// File: tb/tb_scan_chain_host.sv
`timescale 1ns/1ps
module tb_scan_chain_host;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s     [NI];
  logic       tbusy_s     [NI];
  logic       busy_s      [NI];
  logic       done_s      [NI];
  logic [7:0] in_data_s   [NI];
  logic       in_valid_s  [NI];
  logic       in_ready_s  [NI];
  logic [7:0] out_data_s  [NI];
  logic       out_valid_s [NI];
  logic       out_ready_s [NI];
  logic       se_s        [NI];
  logic       si_s        [NI];
  logic       so_s        [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Expected readback bytes of the active session (one instance at a time).
  logic [7:0] exp_q[$];
  // Reference chain contents per instance, in the order the bits will exit.
  bit         mq [NI][136];
  logic [7:0] wr_buf [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: observed 0x%0h at t=%0t", nm, act, $time);
  endtask

  function automatic int len_of(input int k);
    return (k == 0) ? 136 : 12;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned L = (g == 0) ? 136 : 12;
    logic [L-1:0] chain = '0;
    int se_cnt = 0;
    int done_cnt = 0;

    scan_chain_host #(.CHAIN_LEN(L)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_s[g]),
      .target_busy(tbusy_s[g]),
      .busy       (busy_s[g]),
      .done       (done_s[g]),
      .in_data    (in_data_s[g]),
      .in_valid   (in_valid_s[g]),
      .in_ready   (in_ready_s[g]),
      .out_data   (out_data_s[g]),
      .out_valid  (out_valid_s[g]),
      .out_ready  (out_ready_s[g]),
      .scan_enable(se_s[g]),
      .scan_in    (si_s[g]),
      .scan_out   (so_s[g])
    );

    // Target scan chain: cell L-1 is the last one, driving scan_out.
    assign so_s[g] = chain[L-1];
    always @(posedge clk) begin
      if (se_s[g]) chain <= {chain[L-2:0], si_s[g]};
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
      bit final_pend;
      final_pend = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          final_pend = 1'b0;
        end else begin
          if (se_s[g]) se_cnt++;
          if (final_pend) begin
            check("done_after_last_handshake", done_s[g], 1);
            final_pend = 1'b0;
          end
          if (done_s[g]) begin
            done_cnt++;
            check("busy_in_done", busy_s[g], 0);
          end
          if (out_valid_s[g]) begin
            check("scan_enable_in_push", se_s[g], 0);
            if (exp_q.size() == 0) begin
              fail_now("unexpected_out_valid", out_data_s[g]);
            end else if (out_ready_s[g]) begin
              check("readback_byte", out_data_s[g], exp_q.pop_front());
              if (exp_q.size() == 0) final_pend = 1'b1;
            end else begin
              check("out_data_stable_stall", out_data_s[g], exp_q[0]);
            end
          end
        end
      end
    end
  end

  function automatic int get_se(input int k);
    return (k == 0) ? g_inst[0].se_cnt : g_inst[1].se_cnt;
  endfunction

  function automatic int get_done(input int k);
    return (k == 0) ? g_inst[0].done_cnt : g_inst[1].done_cnt;
  endfunction

  // Call at #1 after a rising edge with the instance idle. abort_byte < 0
  // runs a full session; otherwise reset is asserted during that bit.
  task automatic run_session(input int k, input int gap, input int hold_byte,
                             input bit start_noise, input int abort_byte, input int abort_bit);
    int L;
    int nb;
    int s;
    int s0;
    int d0;
    int cnt;
    int tmo;
    int n;
    int x;
    bit nq[136];
    logic [7:0] b;
    L  = len_of(k);
    nb = (L + 7) / 8;
    s  = (abort_byte >= 0) ? abort_byte * 8 + abort_bit : L;
    for (int j = 0; j < nb; j++) begin
      b = '0;
      for (int i = 0; i < 8; i++) if (8 * j + i < L) b[i] = mq[k][8 * j + i];
      exp_q.push_back(b);
    end
    // s bits leave the chain, s write bits enter behind the remaining ones.
    for (int i = 0; i < L; i++) begin
      if (i < L - s) nq[i] = mq[k][i + s];
      else begin
        x = i - (L - s);
        nq[i] = wr_buf[x / 8][x % 8];
      end
    end
    for (int i = 0; i < L; i++) mq[k][i] = nq[i];

    s0 = get_se(k);
    d0 = get_done(k);
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    check("busy_after_start", busy_s[k], 1);
    check("in_ready_after_start", in_ready_s[k], 1);

    for (int j = 0; j < nb; j++) begin
      n = (L - 8 * j >= 8) ? 8 : L - 8 * j;
      if (start_noise && j >= 1 && j <= 3) start_s[k] = 1'b1;
      repeat (gap) begin @(posedge clk); #1; end
      in_data_s[k]  = wr_buf[j];
      in_valid_s[k] = 1'b1;
      tmo = 0;
      while (!in_ready_s[k] && tmo < 100) begin @(posedge clk); #1; tmo++; end
      if (!in_ready_s[k]) begin
        fail_now("in_ready_timeout", j);
        in_valid_s[k] = 1'b0;
        start_s[k] = 1'b0;
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
      in_valid_s[k] = 1'b0;
      in_data_s[k]  = 8'($urandom);
      start_s[k]    = 1'b0;
      cnt = 0;
      while (se_s[k] && cnt < 20) begin
        if (j == abort_byte && cnt == abort_bit) break;
        cnt++;
        @(posedge clk); #1;
      end
      if (j == abort_byte) begin
        rst_n = 1'b0;
        #1;
        check("abort_scan_enable", se_s[k], 0);
        check("abort_busy", busy_s[k], 0);
        check("abort_scan_in", si_s[k], 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_shift_count", get_se(k) - s0, s);
        return;
      end
      check("shifts_per_byte", cnt, n);
      if (hold_byte == j) begin
        out_ready_s[k] = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        out_ready_s[k] = 1'b1;
      end
    end

    tmo = 0;
    while (get_done(k) == d0 && tmo < 50) begin @(posedge clk); #1; tmo++; end
    repeat (2) begin @(posedge clk); #1; end
    check("done_pulses", get_done(k) - d0, 1);
    check("scan_enable_cycles", get_se(k) - s0, L);
    check("readback_all_consumed", exp_q.size(), 0);
    check("idle_after_session", busy_s[k], 0);
    exp_q.delete();
  endtask

  task automatic fill_random(input int nb);
    for (int j = 0; j < nb; j++) wr_buf[j] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0; tbusy_s[k] = 1'b0; in_data_s[k] = '0;
      in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b1;
      for (int i = 0; i < 136; i++) mq[k][i] = 1'b0;
    end
    for (int j = 0; j < 17; j++) wr_buf[j] = '0;

    // Reset: asserted before any clock edge, then held with random inputs.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      check("reset_outputs_async", {busy_s[k], done_s[k], in_ready_s[k], out_valid_s[k],
                                    se_s[k], si_s[k], out_data_s[k]}, 0);
    repeat (5) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        start_s[k] = 1'($urandom); tbusy_s[k] = 1'($urandom);
        in_valid_s[k] = 1'($urandom); in_data_s[k] = 8'($urandom);
        out_ready_s[k] = 1'($urandom);
      end
      #2;
      for (int k = 0; k < NI; k++)
        check("reset_outputs", {busy_s[k], done_s[k], in_ready_s[k], out_valid_s[k],
                                se_s[k], si_s[k], out_data_s[k]}, 0);
    end
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0; tbusy_s[k] = 1'b0; in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b1;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full round trip on the 136-bit chain.
    for (int j = 0; j < 17; j++) wr_buf[j] = 8'(j);
    run_session(0, 0, -1, 1'b0, -1, 0);
    for (int j = 0; j < 17; j++) wr_buf[j] = 8'hFF;
    run_session(0, 0, -1, 1'b0, -1, 0);

    // Partial last byte on the 12-bit chain.
    wr_buf[0] = 8'hA5; wr_buf[1] = 8'h0F;
    run_session(1, 0, -1, 1'b0, -1, 0);
    fill_random(2);
    run_session(1, 1, -1, 1'b0, -1, 0);

    // Output backpressure and input gaps, then read the contents back.
    fill_random(17);
    run_session(0, 5, 3, 1'b0, -1, 0);
    fill_random(17);
    run_session(0, 0, -1, 1'b0, -1, 0);

    // Start gating: target busy, then start pulses inside a session.
    start_s[0] = 1'b1; tbusy_s[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("busy_with_target_busy", busy_s[0], 0);
      check("in_ready_with_target_busy", in_ready_s[0], 0);
    end
    start_s[0] = 1'b0; tbusy_s[0] = 1'b0;
    @(posedge clk); #1;
    fill_random(17);
    run_session(0, 1, -1, 1'b1, -1, 0);

    // Reset during bit 3 of byte 5, then a normal session.
    fill_random(17);
    run_session(0, 0, -1, 1'b0, 5, 3);
    @(posedge clk); #1;
    fill_random(17);
    run_session(0, 0, -1, 1'b0, -1, 0);

    // Random sessions on both chains.
    for (int r = 0; r < 6; r++) begin
      fill_random(17);
      run_session(r % 2, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 0 : -1,
                  1'b0, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
